// File: rtl/rf_writeback_queue.sv
// In-order write-back queue feeding the Reg32x32 write port,
// with a youngest-first hazard/forwarding lookup for decode.
module rf_writeback_queue #(
    parameter int XLEN  = 32,
    parameter int AW    = 5,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [AW-1:0]            in_rd,
    input  logic [XLEN-1:0]          in_data,
    input  logic                     drain_en,
    input  logic                     flush,
    output logic                     rd_we,
    output logic [AW-1:0]            rd_addr,
    output logic [XLEN-1:0]          rd_wdata,
    input  logic [AW-1:0]            chk_addr,
    output logic                     chk_hit,
    output logic [XLEN-1:0]          chk_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    typedef enum logic [1:0] {
        EMPTY,
        ACTIVE,
        FULL
    } state_t;

    state_t            state;
    logic [AW-1:0]     rd_q   [DEPTH];
    logic [XLEN-1:0]   data_q [DEPTH];
    logic [DEPTH-1:0]  valid;
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     idx;
    logic [PW:0]       cnt_nxt;
    logic              store;
    logic              pop;

    always_comb begin
        in_ready = rst | ((state != FULL) & ~flush);
        rd_we    = ~rst & (state != EMPTY) & drain_en & ~flush;
        rd_addr  = rd_we ? rd_q[rd_ptr] : '0;
        rd_wdata = rd_we ? data_q[rd_ptr] : '0;
        pop      = rd_we;
        // x0 writes are accepted from the producer but never stored
        store    = in_valid & in_ready & ~rst & (in_rd != '0);
        cnt_nxt  = count + (PW+1)'(store) - (PW+1)'(pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            valid  <= '0;
            state  <= EMPTY;
        end else if (flush) begin
            rd_ptr <= wr_ptr;
            count  <= '0;
            valid  <= '0;
            state  <= EMPTY;
        end else begin
            if (store) begin
                valid[wr_ptr] <= 1'b1;
                wr_ptr        <= wr_ptr + 1'b1;
            end
            if (pop) begin
                valid[rd_ptr] <= 1'b0;
                rd_ptr        <= rd_ptr + 1'b1;
            end
            count <= cnt_nxt;
            if (cnt_nxt == '0)
                state <= EMPTY;
            else if (cnt_nxt == FULL_CNT)
                state <= FULL;
            else
                state <= ACTIVE;
        end
    end

    always_ff @(posedge clk) begin
        if (store) begin
            rd_q[wr_ptr]   <= in_rd;
            data_q[wr_ptr] <= in_data;
        end
    end

    // Walk oldest to youngest so the youngest match overwrites older ones
    always_comb begin
        chk_hit  = 1'b0;
        chk_data = '0;
        idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PW'(i);
            if (valid[idx] && rd_q[idx] == chk_addr) begin
                chk_hit  = 1'b1;
                chk_data = data_q[idx];
            end
        end
        if (rst || chk_addr == '0) begin
            chk_hit  = 1'b0;
            chk_data = '0;
        end
    end

endmodule

// File: tb/tb_rf_writeback_queue.sv
// Bench for rf_writeback_queue: directed scenarios plus random traffic
// against a queue-based model and a model register file.
module tb_rf_writeback_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd;
    logic [31:0] in_data;
    logic        drain_en;
    logic        flush;
    logic        rd_we;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
    logic [4:0]  chk_addr;
    logic        chk_hit;
    logic [31:0] chk_data;
    logic [2:0]  count;

    int n_tests = 0;
    int n_fail  = 0;

    rf_writeback_queue dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_rd    (in_rd),
        .in_data  (in_data),
        .drain_en (drain_en),
        .flush    (flush),
        .rd_we    (rd_we),
        .rd_addr  (rd_addr),
        .rd_wdata (rd_wdata),
        .chk_addr (chk_addr),
        .chk_hit  (chk_hit),
        .chk_data (chk_data),
        .count    (count)
    );

    always #5 clk = ~clk;

    // Register file written by the DUT (x0 hardwired to zero)
    logic [31:0] obs_rf [32] = '{default: 32'h0};
    always @(posedge clk)
        if (rd_we && rd_addr != 5'd0)
            obs_rf[rd_addr] <= rd_wdata;

    // Reference model: a plain queue of pending writes and a model regfile
    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] exp_rf [32] = '{default: 32'h0};
    bit          m_acc;

    function automatic bit m_ready();
        return (mq.size() < 4) && !flush;
    endfunction

    function automatic bit m_we();
        return (mq.size() != 0) && drain_en && !flush;
    endfunction

    function automatic logic [4:0] m_addr();
        return m_we() ? mq[0].rd : 5'd0;
    endfunction

    function automatic logic [31:0] m_wdata();
        return m_we() ? mq[0].data : 32'd0;
    endfunction

    function automatic bit m_hit();
        if (chk_addr == 5'd0) return 1'b0;
        for (int i = mq.size() - 1; i >= 0; i--)
            if (mq[i].rd == chk_addr) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_data();
        if (chk_addr == 5'd0) return 32'd0;
        for (int i = mq.size() - 1; i >= 0; i--)
            if (mq[i].rd == chk_addr) return mq[i].data;
        return 32'd0;
    endfunction

    task automatic model_step();
        bit   we;
        bit   rdy;
        ent_t e;
        m_acc = 1'b0;
        if (rst || flush) begin
            mq.delete();
            return;
        end
        we  = m_we();
        rdy = m_ready();
        if (we) begin
            e = mq.pop_front();
            exp_rf[e.rd] = e.data;
        end
        if (in_valid && rdy) begin
            m_acc = 1'b1;
            if (in_rd != 5'd0) mq.push_back({in_rd, in_data});
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; in_rd = 5'd5; in_data = 32'h1234_5678;
        drain_en = 1'b1; flush = 1'b0; chk_addr = 5'd5;
        #2;
        n_tests++;
        if (rd_we !== 1'b0 || rd_addr !== 5'd0 || rd_wdata !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_port we=%0b addr=%0d data=%h required 0/0/0", rd_we, rd_addr, rd_wdata);
        end
        n_tests++;
        if (chk_hit !== 1'b0 || chk_data !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_chk hit=%0b data=%h required 0/0", chk_hit, chk_data);
        end
        n_tests++;
        if (in_ready !== 1'b1 || count !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_ready ready=%0b count=%0d required 1/0", in_ready, count);
        end
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_write();
        drain_en = 1'b1; in_valid = 1'b1; in_rd = 5'd5; in_data = 32'hABCA_ABCA;
        chk_addr = 5'd5;
        @(negedge clk);
        n_tests++;
        if (in_ready !== 1'b1 || rd_we !== 1'b0) begin
            n_fail++;
            $display("FAIL single_push ready=%0b we=%0b required 1/0", in_ready, rd_we);
        end
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if (rd_we !== 1'b1 || rd_addr !== 5'd5 || rd_wdata !== 32'hABCA_ABCA) begin
            n_fail++;
            $display("FAIL single_drain we=%0b addr=%0d data=%h required 1/5/abcaabca", rd_we, rd_addr, rd_wdata);
        end
        n_tests++;
        if (chk_hit !== 1'b1 || chk_data !== 32'hABCA_ABCA) begin
            n_fail++;
            $display("FAIL single_retire_hit hit=%0b data=%h required 1/abcaabca", chk_hit, chk_data);
        end
        tick();
        @(negedge clk);
        n_tests++;
        if (rd_we !== 1'b0 || count !== 3'd0 || obs_rf[5] !== 32'hABCA_ABCA) begin
            n_fail++;
            $display("FAIL single_after we=%0b count=%0d x5=%h required 0/0/abcaabca", rd_we, count, obs_rf[5]);
        end
        tick();
    endtask

    task automatic test_fill_drain();
        logic [4:0]  rds [5] = '{5'd3, 5'd7, 5'd10, 5'd20, 5'd9};
        logic [31:0] dat [5] = '{32'hABAB_ABAB, 32'hBABA_BABA, 32'h1111_1111,
                                 32'h2222_2222, 32'h3333_3333};
        bit got5 = 1'b0;
        drain_en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; in_rd = rds[k]; in_data = dat[k];
            tick();
        end
        in_rd = rds[4]; in_data = dat[4];
        @(negedge clk);
        n_tests++;
        if (count !== 3'd4 || in_ready !== 1'b0 || rd_we !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_full count=%0d ready=%0b we=%0b required 4/0/0", count, in_ready, rd_we);
        end
        tick();
        drain_en = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_tests++;
            if (rd_we !== 1'b1 || rd_addr !== rds[k] || rd_wdata !== dat[k]) begin
                n_fail++;
                $display("FAIL drain_order[%0d] we=%0b addr=%0d data=%h required 1/%0d/%h",
                         k, rd_we, rd_addr, rd_wdata, rds[k], dat[k]);
            end
            if (k == 0) begin
                n_tests++;
                if (in_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL no_pop_through ready=%0b required 0", in_ready);
                end
            end
            tick();
            if (m_acc) begin
                got5 = 1'b1;
                in_valid = 1'b0;
            end
        end
        @(negedge clk);
        n_tests++;
        if (count !== 3'd0 || rd_we !== 1'b0 || !got5) begin
            n_fail++;
            $display("FAIL fill_end count=%0d we=%0b accepted5=%0b required 0/0/1", count, rd_we, got5);
        end
        n_tests++;
        if (obs_rf[20] !== 32'h2222_2222 || obs_rf[9] !== 32'h3333_3333) begin
            n_fail++;
            $display("FAIL fill_rf x20=%h x9=%h required 22222222/33333333", obs_rf[20], obs_rf[9]);
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_x0_filter();
        bit seen_we = 1'b0;
        drain_en = 1'b1; in_valid = 1'b1; in_rd = 5'd0; in_data = 32'hFFFF_FFFF;
        @(negedge clk);
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL x0_ready ready=%0b required 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (rd_we) seen_we = 1'b1;
            tick();
        end
        n_tests++;
        if (count !== 3'd0 || seen_we || obs_rf[0] !== 32'd0) begin
            n_fail++;
            $display("FAIL x0_filter count=%0d we_seen=%0b x0=%h required 0/0/0", count, seen_we, obs_rf[0]);
        end
    endtask

    task automatic test_lookup();
        drain_en = 1'b0; in_valid = 1'b1; in_rd = 5'd8; in_data = 32'h0101_0101;
        tick();
        in_data = 32'h2222_2222;
        tick();
        in_valid = 1'b0; chk_addr = 5'd8;
        @(negedge clk);
        n_tests++;
        if (chk_hit !== 1'b1 || chk_data !== 32'h2222_2222) begin
            n_fail++;
            $display("FAIL lookup_youngest hit=%0b data=%h required 1/22222222", chk_hit, chk_data);
        end
        chk_addr = 5'd9;
        #1;
        n_tests++;
        if (chk_hit !== 1'b0 || chk_data !== 32'd0) begin
            n_fail++;
            $display("FAIL lookup_miss hit=%0b data=%h required 0/0", chk_hit, chk_data);
        end
        chk_addr = 5'd0;
        #1;
        n_tests++;
        if (chk_hit !== 1'b0 || chk_data !== 32'd0) begin
            n_fail++;
            $display("FAIL lookup_x0 hit=%0b data=%h required 0/0", chk_hit, chk_data);
        end
        drain_en = 1'b1;
        tick();
        tick();
        tick();
        n_tests++;
        if (obs_rf[8] !== 32'h2222_2222 || count !== 3'd0) begin
            n_fail++;
            $display("FAIL lookup_drain x8=%h count=%0d required 22222222/0", obs_rf[8], count);
        end
    endtask

    task automatic test_flush();
        logic [31:0] snap [4];
        bit seen_we = 1'b0;
        for (int k = 0; k < 4; k++) snap[k] = obs_rf[11 + k];
        drain_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; in_rd = 5'(11 + k); in_data = 32'hF00D_0000 + 32'(k);
            tick();
        end
        flush = 1'b1; in_rd = 5'd14; in_data = 32'hDEAD_BEEF; drain_en = 1'b1;
        @(negedge clk);
        n_tests++;
        if (in_ready !== 1'b0 || rd_we !== 1'b0 || count !== 3'd3) begin
            n_fail++;
            $display("FAIL flush_cycle ready=%0b we=%0b count=%0d required 0/0/3", in_ready, rd_we, count);
        end
        tick();
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if (count !== 3'd0) begin
            n_fail++;
            $display("FAIL flush_count count=%0d required 0", count);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (rd_we) seen_we = 1'b1;
            tick();
        end
        n_tests++;
        if (seen_we || obs_rf[11] !== snap[0] || obs_rf[12] !== snap[1]
            || obs_rf[13] !== snap[2] || obs_rf[14] !== snap[3]) begin
            n_fail++;
            $display("FAIL flush_discard we_seen=%0b x11=%h x14=%h required 0/%h/%h",
                     seen_we, obs_rf[11], obs_rf[14], snap[0], snap[3]);
        end
    endtask

    task automatic test_async_reset();
        drain_en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; in_rd = 5'(21 + k); in_data = 32'hC0DE_0000 + 32'(k);
            tick();
        end
        in_valid = 1'b0; drain_en = 1'b1;
        tick();
        tick();
        chk_addr = 5'd24;
        #2;
        rst = 1'b1;
        #1;
        n_tests++;
        if (rd_we !== 1'b0 || count !== 3'd0 || in_ready !== 1'b1 || chk_hit !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset we=%0b count=%0d ready=%0b hit=%0b required 0/0/1/0",
                     rd_we, count, in_ready, chk_hit);
        end
        mq.delete();
        tick();
        @(negedge clk);
        rst = 1'b0;
        tick();
        in_valid = 1'b1; in_rd = 5'd5; in_data = 32'h5555_AAAA;
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if (rd_we !== 1'b1 || rd_addr !== 5'd5 || rd_wdata !== 32'h5555_AAAA) begin
            n_fail++;
            $display("FAIL post_reset_push we=%0b addr=%0d data=%h required 1/5/5555aaaa", rd_we, rd_addr, rd_wdata);
        end
        tick();
        n_tests++;
        if (obs_rf[5] !== 32'h5555_AAAA || obs_rf[23] !== exp_rf[23] || obs_rf[24] !== exp_rf[24]) begin
            n_fail++;
            $display("FAIL post_reset_rf x5=%h x23=%h x24=%h required 5555aaaa/%h/%h",
                     obs_rf[5], obs_rf[23], obs_rf[24], exp_rf[23], exp_rf[24]);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_rd    = 5'($urandom_range(0, 7));
            in_data  = $urandom;
            drain_en = ($urandom_range(0, 9) < 6);
            flush    = ($urandom_range(0, 24) == 0);
            chk_addr = 5'($urandom_range(0, 7));
            @(negedge clk);
            n_tests++;
            if (in_ready !== m_ready() || count !== 3'(mq.size())) begin
                n_fail++;
                $display("FAIL rnd_ready[%0d] ready=%0b count=%0d required %0b/%0d",
                         c, in_ready, count, m_ready(), mq.size());
            end
            n_tests++;
            if (rd_we !== m_we() || rd_addr !== m_addr() || rd_wdata !== m_wdata()) begin
                n_fail++;
                $display("FAIL rnd_port[%0d] we=%0b addr=%0d data=%h required %0b/%0d/%h",
                         c, rd_we, rd_addr, rd_wdata, m_we(), m_addr(), m_wdata());
            end
            n_tests++;
            if (chk_hit !== m_hit() || chk_data !== m_data()) begin
                n_fail++;
                $display("FAIL rnd_chk[%0d] addr=%0d hit=%0b data=%h required %0b/%h",
                         c, chk_addr, chk_hit, chk_data, m_hit(), m_data());
            end
            tick();
        end
        in_valid = 1'b0; flush = 1'b0; drain_en = 1'b1;
        for (int k = 0; k < 6; k++) tick();
        for (int r = 0; r < 32; r++) begin
            n_tests++;
            if (obs_rf[r] !== exp_rf[r]) begin
                n_fail++;
                $display("FAIL rnd_rf x%0d=%h required %h", r, obs_rf[r], exp_rf[r]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_fill_drain();
        test_x0_filter();
        test_lookup();
        test_flush();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
